exp_controller: RTL and testbench

EXP_CONTROLLER -- requirements
Module: exp_controller

---
 rtl/exp_controller.sv | 106 ++++++++++
 tb/tb_exp_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_controller.sv
// Purpose : Moore FSM sequencing a 16-term series-sum datapath (load, multiply by x, multiply by LUT term, accumulate).
// Latency : done rises 49 edges after the edge that accepts start, with 16 MULX/MULC/ACC iterations.
// Backpres: start is taken only while ready=1 and is never queued; the result is held in DONE until ack.
// Ports   : clk, rst (async active-low); start/ack handshake; co = term counter at 15;
//           zx..s = datapath register, counter and mux controls; ready = idle; done = result valid.
module exp_controller (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ack,
    input  logic co,
    output logic zx,
    output logic initx,
    output logic ldx,
    output logic zt,
    output logic initt,
    output logic ldt,
    output logic zr,
    output logic initr,
    output logic ldr,
    output logic zc,
    output logic ldc,
    output logic enc,
    output logic s,
    output logic ready,
    output logic done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MULX = 3'd2,
        S_MULC = 3'd3,
        S_ACC  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; encodings 6 and 7 fall through to IDLE
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:  state_nxt = start ? S_LOAD : S_IDLE;
            S_LOAD:  state_nxt = S_MULX;
            S_MULX:  state_nxt = S_MULC;
            S_MULC:  state_nxt = S_ACC;
            // co is only meaningful here: the counter has just reached its last term
            S_ACC:   state_nxt = co ? S_DONE : S_MULX;
            // ack wins over a simultaneous start; start is dropped, not remembered
            S_DONE:  state_nxt = ack ? S_IDLE : S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the state register only
    always_comb begin
        zx    = 1'b0;
        initx = 1'b0;
        ldx   = 1'b0;
        zt    = 1'b0;
        initt = 1'b0;
        ldt   = 1'b0;
        zr    = 1'b0;
        initr = 1'b0;
        ldr   = 1'b0;
        zc    = 1'b0;
        ldc   = 1'b0;
        enc   = 1'b0;
        s     = 1'b0;
        ready = 1'b0;
        done  = 1'b0;
        // zx, initx, zt, zr and ldc stay low everywhere; they are reserved for a later soft-clear
        case (state)
            S_IDLE: ready = 1'b1;
            S_LOAD: begin
                ldx   = 1'b1;
                initt = 1'b1;
                initr = 1'b1;
                zc    = 1'b1;
            end
            S_MULX: ldt = 1'b1;
            S_MULC: begin
                ldt = 1'b1;
                s   = 1'b1;
            end
            S_ACC: begin
                ldr = 1'b1;
                enc = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exp_controller.sv
module tb_exp_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic ack = 1'b0;
    logic co;
    logic zx, initx, ldx, zt, initt, ldt, zr, initr, ldr, zc, ldc, enc, s, ready, done;

    exp_controller dut (
        .clk(clk), .rst(rst), .start(start), .ack(ack), .co(co),
        .zx(zx), .initx(initx), .ldx(ldx), .zt(zt), .initt(initt), .ldt(ldt),
        .zr(zr), .initr(initr), .ldr(ldr), .zc(zc), .ldc(ldc), .enc(enc), .s(s),
        .ready(ready), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int done_rises = 0;
    int step = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed control word: ready,done,zx,initx,ldx,zt,initt,ldt,zr,initr,ldr,zc,ldc,enc,s
    wire [14:0] obs = {ready, done, zx, initx, ldx, zt, initt, ldt, zr, initr, ldr, zc, ldc, enc, s};

    localparam logic [14:0] V_IDLE = 15'h4000;
    localparam logic [14:0] V_LOAD = 15'h0528;  // ldx, initt, initr, zc
    localparam logic [14:0] V_MULX = 15'h0080;  // ldt
    localparam logic [14:0] V_MULC = 15'h0081;  // ldt, s
    localparam logic [14:0] V_ACC  = 15'h0012;  // ldr, enc
    localparam logic [14:0] V_DONE = 15'h2000;
    localparam logic [31:0] ONE    = 32'h0001_0000;  // Q16.16

    // Reference datapath driven by the controller's outputs
    logic [31:0] lut [16];
    logic [31:0] x_in = 32'h0;
    logic [31:0] x_reg, temp, result;
    logic [3:0]  cnt;

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        return p[47:16];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_reg  <= '0;
            temp   <= '0;
            result <= '0;
            cnt    <= '0;
        end else begin
            if (ldx) x_reg <= x_in;
            if (initt)    temp <= ONE;
            else if (ldt) temp <= fmul(temp, s ? lut[cnt] : x_reg);
            if (initr)    result <= ONE;
            else if (ldr) result <= result + temp;
            if (zc)       cnt <= '0;
            else if (enc) cnt <= cnt + 4'd1;
        end
    end
    assign co = (cnt == 4'd15);

    // Golden series: sum_{k=0..16} x^k/k! with truncating fixed-point steps
    function automatic logic [31:0] golden(input logic [31:0] x);
        logic [31:0] t, r;
        t = ONE;
        r = ONE;
        for (int k = 0; k < 16; k++) begin
            t = fmul(t, x);
            t = fmul(t, lut[k]);
            r = r + t;
        end
        return r;
    endfunction

    // Scoreboard queues
    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;
    exp_t        res_q [$];
    logic [14:0] trace_q [$];
    exp_t        r_exp;
    logic [14:0] t_exp;

    // Monitor: compares whatever the DUT presents against the queued expectations
    always @(negedge clk) begin
        if (rst) begin
            if (trace_q.size() > 0) begin
                t_exp = trace_q.pop_front();
                checks++;
                if (obs !== t_exp) begin
                    errors++;
                    $display("FAIL trace step %0d: got %h want %h", step, obs, t_exp);
                end
                step++;
            end
            if (done && !prev_done) begin
                done_rises++;
                checks++;
                if (res_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done at cycle %0d", cyc);
                end else begin
                    r_exp = res_q.pop_front();
                    if (result !== r_exp.res || (cyc - accept_cyc) != r_exp.lat) begin
                        errors++;
                        $display("FAIL result: got %h lat %0d want %h lat %0d",
                                 result, cyc - accept_cyc, r_exp.res, r_exp.lat);
                    end
                end
            end
        end
        prev_done = done;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the start-accepting edge
    task automatic push_run(input logic [31:0] x);
        accept_cyc = cyc;
        trace_q.push_back(V_LOAD);
        for (int i = 0; i < 16; i++) begin
            trace_q.push_back(V_MULX);
            trace_q.push_back(V_MULC);
            trace_q.push_back(V_ACC);
        end
        trace_q.push_back(V_DONE);
        res_q.push_back('{golden(x), 49});
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=0 want done=1 within 100 cycles");
        end
    endtask

    task automatic run(input logic [31:0] x, input bit hold, input bit ack_mulc);
        x_in  = x;
        start = 1'b1;
        tick();
        push_run(x);
        if (!hold) start = 1'b0;
        if (ack_mulc) begin
            tick();          // MULX
            tick();          // MULC
            ack = 1'b1;      // sampled at the MULC->ACC edge
            tick();
            ack = 1'b0;
        end
        wait_done();
    endtask

    task automatic ack_done();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        trace_q.push_back(V_IDLE);
    endtask

    int rises_before;

    initial begin
        for (int k = 0; k < 16; k++) lut[k] = 32'(65536 / (k + 1));

        // Reset state before and after the first clock
        #3;
        chk("reset_async", 32'(obs), 32'(V_IDLE));
        tick();
        chk("reset_held", 32'(obs), 32'(V_IDLE));
        rst = 1'b1;
        tick();
        chk("post_reset_clk1", 32'(obs), 32'(V_IDLE));
        tick();
        chk("idle_no_start", 32'(obs), 32'(V_IDLE));

        // Run 1: x=0, ack pulsed during MULC, start ignored while in DONE
        run(32'h0, 1'b0, 1'b1);
        chk("x0_result", result, ONE);
        for (int i = 0; i < 3; i++) begin
            start = (i != 2);
            tick();
            trace_q.push_back(V_DONE);
        end
        start = 1'b0;
        ack_done();
        tick();
        trace_q.push_back(V_IDLE);

        // Run 2: x=1.0 with start held: re-accepted one cycle after DONE exits
        run(ONE, 1'b1, 1'b0);
        ack_done();
        tick();              // second accept edge
        push_run(ONE);
        start = 1'b0;
        wait_done();
        ack_done();
        tick();
        trace_q.push_back(V_IDLE);

        // Run 3: x=0.5, then start+ack together in DONE gives no restart
        run(32'h0000_8000, 1'b0, 1'b0);
        start = 1'b1;
        ack   = 1'b1;
        tick();
        start = 1'b0;
        ack   = 1'b0;
        trace_q.push_back(V_IDLE);
        for (int i = 0; i < 2; i++) begin
            tick();
            trace_q.push_back(V_IDLE);
        end
        tick();

        // Reset asserted in the 7th MULC
        x_in  = ONE;
        start = 1'b1;
        tick();
        push_run(ONE);
        start = 1'b0;
        repeat (20) tick();
        chk("seventh_mulc", 32'(obs), 32'(V_MULC));
        #1 rst = 1'b0;
        #1;
        chk("reset_mid_async", 32'(obs), 32'(V_IDLE));
        trace_q.delete();
        res_q.delete();
        rises_before = done_rises;
        tick();
        chk("reset_mid_held", 32'(obs), 32'(V_IDLE));
        rst = 1'b1;
        repeat (60) tick();
        chk("no_done_after_reset", 32'(done_rises), 32'(rises_before));
        chk("idle_after_reset", 32'(obs), 32'(V_IDLE));

        // Full run after the abandoned one
        run(ONE, 1'b0, 1'b0);
        ack_done();
        repeat (3) tick();
        chk("queues_drained", 32'(trace_q.size() + res_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
